huffman_code_packer: RTL and testbench



---
 rtl/huffman_code_packer_if.sv | 32 +++
 rtl/huffman_code_packer.sv | 92 +++++++++
 tb/tb_huffman_code_packer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_code_packer_if.sv
// Valid/ready bundle between the Huffman encoder, the code packer and the
// downstream word consumer.
interface huffman_code_packer_if #(
    parameter int IN_CODE_WIDTH = 64,
    parameter int IN_LEN_WIDTH  = 7,
    parameter int OUT_WIDTH     = 32
);
    localparam int NBYTES_WIDTH = $clog2(OUT_WIDTH / 8) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [IN_CODE_WIDTH-1:0] in_code;
    logic [IN_LEN_WIDTH-1:0]  in_len;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_WIDTH-1:0]     out_data;
    logic                     out_last;
    logic [NBYTES_WIDTH-1:0]  out_nbytes;

    // The master drives code beats and absorbs packed words.
    modport master (
        output in_valid, in_code, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbytes
    );

    modport slave (
        input  in_valid, in_code, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbytes
    );
endinterface

// File: rtl/huffman_code_packer.sv
// Packs variable-length LSB-first Deflate codes into fixed-width words, with
// optional fixed-Huffman block header and zero-padded end-of-stream flush.
module huffman_code_packer #(
    parameter int IN_CODE_WIDTH = 64,
    parameter int IN_LEN_WIDTH  = 7,
    parameter int OUT_WIDTH     = 32,
    parameter bit EMIT_HEADER   = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    huffman_code_packer_if.slave bus
);
    localparam int ACC_WIDTH    = IN_CODE_WIDTH + OUT_WIDTH;
    localparam int CNT_WIDTH    = $clog2(ACC_WIDTH + 1);
    localparam int NBYTES_WIDTH = $clog2(OUT_WIDTH / 8) + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Fixed-Huffman header: BFINAL=1 then BTYPE=01, transmitted LSB first.
    localparam logic [ACC_WIDTH-1:0] INIT_ACC = EMIT_HEADER ? ACC_WIDTH'(3'b011) : '0;
    localparam logic [CNT_WIDTH-1:0] INIT_CNT = EMIT_HEADER ? CNT_WIDTH'(3) : '0;
    localparam logic [CNT_WIDTH-1:0] OUT_BITS = CNT_WIDTH'(OUT_WIDTH);

    logic [ACC_WIDTH-1:0]     acc;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [0:0]               state;

    logic                     in_ready_int;
    logic                     out_valid_int;
    logic                     out_last_int;
    logic                     accept;
    logic                     emit;
    logic [IN_CODE_WIDTH-1:0] code_mask;
    logic [ACC_WIDTH-1:0]     code_shifted;
    logic [CNT_WIDTH:0]       cnt_round_up;

    assign in_ready_int  = (state == ST_RUN) && (cnt < OUT_BITS);
    assign out_valid_int = (cnt >= OUT_BITS) || (state == ST_FLUSH);
    assign out_last_int  = (state == ST_FLUSH) && (cnt <= OUT_BITS);

    assign accept = bus.in_valid && in_ready_int;
    assign emit   = out_valid_int && bus.out_ready;

    // Clearing bits above in_len keeps acc zero above cnt, which is what
    // makes the final-word padding come out as zeros.
    always_comb begin
        code_mask = '1;
        if (bus.in_len < IN_LEN_WIDTH'(IN_CODE_WIDTH)) begin
            code_mask = ~({IN_CODE_WIDTH{1'b1}} << bus.in_len);
        end
    end

    assign code_shifted = ACC_WIDTH'(bus.in_code & code_mask) << cnt;
    assign cnt_round_up = {1'b0, cnt} + (CNT_WIDTH + 1)'(7);

    // NOTE: every register here is clocked with non-blocking assignments and
    // the synchronous reset reloads the whole accumulator, so no stale bits
    // from an aborted stream can leak into the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= INIT_ACC;
            cnt   <= INIT_CNT;
            state <= ST_RUN;
        end else if (emit) begin
            if (out_last_int) begin
                acc   <= INIT_ACC;
                cnt   <= INIT_CNT;
                state <= ST_RUN;
            end else begin
                acc <= acc >> OUT_WIDTH;
                cnt <= cnt - OUT_BITS;
            end
        end else if (accept) begin
            acc <= acc | code_shifted;
            cnt <= cnt + CNT_WIDTH'(bus.in_len);
            if (bus.in_last) begin
                state <= ST_FLUSH;
            end
        end
    end

    // While idle the byte field reports the pending partial count, so a
    // header-only packer shows one byte out of reset.
    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_int;
    assign bus.out_last   = out_last_int;
    assign bus.out_data   = out_valid_int ? acc[OUT_WIDTH-1:0] : '0;
    assign bus.out_nbytes = (out_last_int || !out_valid_int)
                          ? NBYTES_WIDTH'(cnt_round_up >> 3)
                          : NBYTES_WIDTH'(OUT_WIDTH / 8);
endmodule

// File: tb/tb_huffman_code_packer.sv
// Scoreboard bench: one packer with header insertion and one without, fed
// directed code beats; monitors compare every accepted word against queues.
module tb_huffman_code_packer;
    localparam int ICW = 64;
    localparam int ILW = 7;
    localparam int OW  = 32;
    localparam int NBW = $clog2(OW / 8) + 1;

    typedef struct packed {
        logic [OW-1:0]  data;
        logic           last;
        logic [NBW-1:0] nbytes;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    huffman_code_packer_if #(.IN_CODE_WIDTH(ICW), .IN_LEN_WIDTH(ILW), .OUT_WIDTH(OW)) if_h ();
    huffman_code_packer_if #(.IN_CODE_WIDTH(ICW), .IN_LEN_WIDTH(ILW), .OUT_WIDTH(OW)) if_r ();

    huffman_code_packer #(
        .IN_CODE_WIDTH(ICW), .IN_LEN_WIDTH(ILW), .OUT_WIDTH(OW), .EMIT_HEADER(1'b1)
    ) u_hdr (.clk(clk), .rst_n(rst_n), .bus(if_h));

    huffman_code_packer #(
        .IN_CODE_WIDTH(ICW), .IN_LEN_WIDTH(ILW), .OUT_WIDTH(OW), .EMIT_HEADER(1'b0)
    ) u_raw (.clk(clk), .rst_n(rst_n), .bus(if_r));

    word_t q_h[$];
    word_t q_r[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_hdr
        word_t e;
        if (rst_n && if_h.out_valid && if_h.out_ready) begin
            if (q_h.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL hdr_unexpected_word: got %0h, required no word", if_h.out_data);
            end else begin
                e = q_h.pop_front();
                check("hdr_data", 64'(if_h.out_data), 64'(e.data));
                check("hdr_last", 64'(if_h.out_last), 64'(e.last));
                check("hdr_nbytes", 64'(if_h.out_nbytes), 64'(e.nbytes));
            end
        end
    end

    always @(negedge clk) begin : mon_raw
        word_t e;
        if (rst_n && if_r.out_valid && if_r.out_ready) begin
            if (q_r.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL raw_unexpected_word: got %0h, required no word", if_r.out_data);
            end else begin
                e = q_r.pop_front();
                check("raw_data", 64'(if_r.out_data), 64'(e.data));
                check("raw_last", 64'(if_r.out_last), 64'(e.last));
                check("raw_nbytes", 64'(if_r.out_nbytes), 64'(e.nbytes));
            end
        end
    end

    task automatic drive(input bit sel, input bit v, input logic [63:0] code, input int len,
                         input bit last);
        if (sel) begin
            if_r.in_valid = v;
            if_r.in_code  = code;
            if_r.in_len   = ILW'(len);
            if_r.in_last  = last;
        end else begin
            if_h.in_valid = v;
            if_h.in_code  = code;
            if_h.in_len   = ILW'(len);
            if_h.in_last  = last;
        end
    endtask

    // sel: 0 = header packer, 1 = raw packer
    task automatic send(input bit sel, input logic [63:0] code, input int len, input bit last);
        int t    = 0;
        bit done = 1'b0;
        @(posedge clk);
        #1;
        drive(sel, 1'b1, code, len, last);
        while (!done && t < 100) begin
            @(negedge clk);
            if (sel ? if_r.in_ready : if_h.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        drive(sel, 1'b0, '0, 0, 1'b0);
        check(sel ? "raw_beat_accepted" : "hdr_beat_accepted", 64'(done), 64'(1));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q_h.size() != 0 || q_r.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("hdr_queue_drained", 64'(q_h.size()), 64'(0));
        check("raw_queue_drained", 64'(q_r.size()), 64'(0));
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 0, 1'b0);
        drive(1'b1, 1'b0, '0, 0, 1'b0);
        if_h.out_ready = 1'b1;
        if_r.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_in_ready", 64'(if_h.in_ready), 64'(1));
        check("rst_hdr_out_valid", 64'(if_h.out_valid), 64'(0));
        check("rst_hdr_out_data", 64'(if_h.out_data), 64'(0));
        check("rst_hdr_out_last", 64'(if_h.out_last), 64'(0));
        check("rst_hdr_out_nbytes", 64'(if_h.out_nbytes), 64'(1));
        check("rst_raw_in_ready", 64'(if_r.in_ready), 64'(1));
        check("rst_raw_out_valid", 64'(if_r.out_valid), 64'(0));
        check("rst_raw_out_data", 64'(if_r.out_data), 64'(0));
        check("rst_raw_out_last", 64'(if_r.out_last), 64'(0));
        check("rst_raw_out_nbytes", 64'(if_r.out_nbytes), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Header plus a 7-bit zero code: 10 bits, two bytes.
        q_h.push_back('{data: 32'h0000_0003, last: 1'b1, nbytes: 3'd2});
        send(1'b0, 64'h0, 7, 1'b0 | 1'b1);
        wait_drain();

        // Header plus 36 ones spill into a second word.
        q_h.push_back('{data: 32'hFFFF_FFFB, last: 1'b0, nbytes: 3'd4});
        q_h.push_back('{data: 32'h0000_007F, last: 1'b1, nbytes: 3'd1});
        for (int i = 0; i < 4; i++) send(1'b0, 64'h1FF, 9, 1'b0);
        send(1'b0, 64'h0, 0, 1'b1);
        wait_drain();

        // Bits above in_len are dropped; exactly 32 bits fill a final word.
        q_r.push_back('{data: 32'h0000_000F, last: 1'b1, nbytes: 3'd4});
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b0);
        send(1'b1, 64'h0, 28, 1'b1);
        wait_drain();

        // Backpressure: word held stable for ten cycles, then released.
        if_h.out_ready = 1'b0;
        q_h.push_back('{data: 32'h5E68_91A3, last: 1'b0, nbytes: 3'd4});
        q_h.push_back('{data: 32'h0000_0005, last: 1'b1, nbytes: 3'd1});
        send(1'b0, 64'hABCD_1234, 32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(if_h.out_valid), 64'(1));
            check("stall_out_data", 64'(if_h.out_data), 64'h5E68_91A3);
            check("stall_out_last", 64'(if_h.out_last), 64'(0));
            check("stall_in_ready", 64'(if_h.in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        if_h.out_ready = 1'b1;
        send(1'b0, 64'h0, 0, 1'b1);
        wait_drain();

        // Empty stream gives one zero word, then a new stream starts at once.
        q_r.push_back('{data: 32'h0000_0000, last: 1'b1, nbytes: 3'd0});
        q_r.push_back('{data: 32'h0000_005A, last: 1'b1, nbytes: 3'd1});
        send(1'b1, 64'h0, 0, 1'b1);
        @(negedge clk);
        check("empty_out_valid", 64'(if_r.out_valid), 64'(1));
        @(negedge clk);
        check("restart_in_ready", 64'(if_r.in_ready), 64'(1));
        send(1'b1, 64'h5A, 8, 1'b1);
        wait_drain();

        // Reset in the middle of a stalled flush drops the pending word.
        if_h.out_ready = 1'b0;
        send(1'b0, 64'h0, 5, 1'b1);
        @(negedge clk);
        check("flush_out_valid", 64'(if_h.out_valid), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(if_h.out_valid), 64'(0));
        check("midrst_in_ready", 64'(if_h.in_ready), 64'(1));
        check("midrst_out_data", 64'(if_h.out_data), 64'(0));
        @(posedge clk);
        #1;
        if_h.out_ready = 1'b1;
        q_h.push_back('{data: 32'h0000_00FB, last: 1'b1, nbytes: 3'd1});
        send(1'b0, 64'h1F, 5, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
